// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle, non-pipelined instruction fetch stage.
// Holds the PC and fetches one instruction word at a time from instruction
// memory over a req/ready handshake. The word is presented to the control
// unit, and the next PC is then chosen from fetch_op/jump_control. The block
// stops fetching on fetch_op=3 and leaves that state only on reset.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   fetch_op, jump_control     next-PC selection from the control unit
//   branch_cond                datapath branch condition
//   jmp_addr                   sign-extended relative offset (base = pc)
//   jr_addr                    absolute jump-register target
//   stall                      holds EXEC; pc does not advance
//   imem_req/addr/ready/rdata  instruction memory read handshake
//   instr, instr_valid         registered instruction for the control unit
//   pc, pc_plus1               current PC and its link value (pc+1)
//   halted                     fetching has stopped
module instr_fetch_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        fetch_op,
  input  logic              jump_control,
  input  logic              branch_cond,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic [ADDR_W-1:0] jr_addr,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] instr_r;
  logic              req_r;
  logic              valid_r;
  logic              halted_r;
  logic [ADDR_W-1:0] pc_plus1_s;
  logic [ADDR_W-1:0] next_pc_s;

  // Link value; wraps naturally at 2^ADDR_W.
  assign pc_plus1_s = pc_r + PC_ONE;

  // Next-PC selection; relative targets are based on the current pc.
  always_comb begin
    next_pc_s = pc_plus1_s;
    case (fetch_op)
      2'd0: next_pc_s = pc_plus1_s;
      2'd1: begin
        if (jump_control || branch_cond) begin
          next_pc_s = pc_r + jmp_addr;
        end else begin
          next_pc_s = pc_plus1_s;
        end
      end
      2'd2:    next_pc_s = jr_addr;
      2'd3:    next_pc_s = pc_r;
      default: next_pc_s = pc_r;
    endcase
  end

  // FSM with registered handshake/status flags. req_r is cleared by the
  // async reset, so a pending request drops the instant rst_n falls and any
  // late imem_ready is ignored because IDLE never looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PC;
      instr_r  <= {DATA_W{1'b0}};
      req_r    <= 1'b0;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= FETCH;
          req_r   <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr_r <= imem_rdata;
            state_r <= EXEC;
            req_r   <= 1'b0;
            valid_r <= 1'b1;
          end else begin
            state_r <= FETCH;
          end
        end
        EXEC: begin
          if (stall) begin
            state_r <= EXEC;
          end else if (fetch_op == 2'd3) begin
            state_r  <= HALT;
            valid_r  <= 1'b0;
            halted_r <= 1'b1;
          end else begin
            pc_r    <= next_pc_s;
            state_r <= FETCH;
            valid_r <= 1'b0;
            req_r   <= 1'b1;
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r  <= IDLE;
          req_r    <= 1'b0;
          valid_r  <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign pc_plus1    = pc_plus1_s;
  assign instr       = instr_r;
  assign instr_valid = valid_r;
  assign halted      = halted_r;

endmodule
